// File: rtl/avl_mem_responder_if.sv
// avl_mem_responder_if: Avalon-MM command/response bundle between a
// requester (master) and the memory responder (slave).
//   avl_write_req / avl_read_req / avl_addr / avl_wdata : master -> slave
//   avl_ready / avl_rdata / avl_rdata_valid             : slave -> master
interface avl_mem_responder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 29
);
    logic                  avl_write_req;
    logic                  avl_read_req;
    logic [ADDR_WIDTH-1:0] avl_addr;
    logic [DATA_WIDTH-1:0] avl_wdata;
    logic                  avl_ready;
    logic [DATA_WIDTH-1:0] avl_rdata;
    logic                  avl_rdata_valid;

    modport master (
        output avl_write_req,
        output avl_read_req,
        output avl_addr,
        output avl_wdata,
        input  avl_ready,
        input  avl_rdata,
        input  avl_rdata_valid
    );

    modport slave (
        input  avl_write_req,
        input  avl_read_req,
        input  avl_addr,
        input  avl_wdata,
        output avl_ready,
        output avl_rdata,
        output avl_rdata_valid
    );
endinterface

// File: rtl/avl_mem_responder.sv
// avl_mem_responder: Avalon-MM slave memory model with init delay,
// fixed-latency in-order read return and optional periodic back-pressure.
// Ports: clk, reset (sync, active-low), avl (slave modport of
// avl_mem_responder_if), ram_rdy (init done, sticky), cmd_err (sticky,
// set on simultaneous write+read). Optional stalls: define AVL_RESP_STALL_EN.
module avl_mem_responder #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 29,
    parameter int MEM_ADDR_BITS = 10,
    parameter int RD_LATENCY    = 4,
    parameter int INIT_CYCLES   = 16,
    parameter int BUSY_PERIOD   = 8,
    parameter int STALL_CYCLES  = 2
) (
    input  logic               clk,
    input  logic               reset,
    avl_mem_responder_if.slave avl,
    output logic               ram_rdy,
    output logic               cmd_err
);

    localparam int DEPTH = 1 << MEM_ADDR_BITS;

    typedef enum logic [1:0] {
        S_INIT  = 2'b00,
        S_READY = 2'b01,
        S_STALL = 2'b10
    } state_t;

    state_t                   state;
    logic [7:0]               init_cnt;
    logic [DATA_WIDTH-1:0]    mem [DEPTH];
    logic [MEM_ADDR_BITS-1:0] idx;
    logic                     wr_acc;
    logic                     rd_acc;
    logic [DATA_WIDTH-1:0]    pipe_dat [RD_LATENCY];
    logic [RD_LATENCY-1:0]    pipe_vld;

    assign idx    = avl.avl_addr[MEM_ADDR_BITS-1:0];
    // avl_ready is only ever 1 after init, so it alone gates acceptance.
    assign wr_acc = avl.avl_ready & avl.avl_write_req;
    // A simultaneous read is dropped in favour of the write.
    assign rd_acc = avl.avl_ready & avl.avl_read_req & ~avl.avl_write_req;

    generate
        if (ADDR_WIDTH > MEM_ADDR_BITS) begin : g_alias
            // Upper address bits alias onto the same storage.
            logic unused_hi;
            assign unused_hi = ^avl.avl_addr[ADDR_WIDTH-1:MEM_ADDR_BITS];
        end
    endgenerate

`ifdef AVL_RESP_STALL_EN
    logic [15:0] busy_cnt;
    logic [15:0] stall_cnt;
    logic        cmd_acc;

    assign cmd_acc = wr_acc | rd_acc;
`else
    logic [31:0] unused_cfg;
    assign unused_cfg = 32'(BUSY_PERIOD) ^ 32'(STALL_CYCLES);
`endif

    // Storage is never cleared; no write lands on a reset edge.
    always_ff @(posedge clk) begin
        if (reset && wr_acc) begin
            mem[idx] <= avl.avl_wdata;
        end
    end

    // Data half of the read pipeline needs no reset: valid bits qualify it.
    always_ff @(posedge clk) begin
        pipe_dat[0] <= mem[idx];
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_dat[i] <= pipe_dat[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pipe_vld            <= '0;
            avl.avl_rdata_valid <= 1'b0;
            avl.avl_rdata       <= '0;
        end else begin
            pipe_vld            <= (pipe_vld << 1) | RD_LATENCY'(rd_acc);
            avl.avl_rdata_valid <= pipe_vld[RD_LATENCY-1];
            avl.avl_rdata       <= pipe_vld[RD_LATENCY-1] ?
                                   pipe_dat[RD_LATENCY-1] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= S_INIT;
            init_cnt      <= '0;
            ram_rdy       <= 1'b0;
            avl.avl_ready <= 1'b0;
            cmd_err       <= 1'b0;
`ifdef AVL_RESP_STALL_EN
            busy_cnt      <= '0;
            stall_cnt     <= '0;
`endif
        end else begin
            if (wr_acc && avl.avl_read_req) begin
                cmd_err <= 1'b1;
            end
            unique case (state)
                S_INIT: begin
                    if (init_cnt == 8'(INIT_CYCLES - 1)) begin
                        state         <= S_READY;
                        ram_rdy       <= 1'b1;
                        avl.avl_ready <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt + 8'd1;
                    end
                end
                S_READY: begin
`ifdef AVL_RESP_STALL_EN
                    if (cmd_acc) begin
                        if (busy_cnt == 16'(BUSY_PERIOD - 1)) begin
                            state         <= S_STALL;
                            avl.avl_ready <= 1'b0;
                            busy_cnt      <= '0;
                            stall_cnt     <= '0;
                        end else begin
                            busy_cnt <= busy_cnt + 16'd1;
                        end
                    end
`endif
                end
`ifdef AVL_RESP_STALL_EN
                S_STALL: begin
                    if (stall_cnt == 16'(STALL_CYCLES - 1)) begin
                        state         <= S_READY;
                        avl.avl_ready <= 1'b1;
                    end else begin
                        stall_cnt <= stall_cnt + 16'd1;
                    end
                end
`endif
                default: begin
                    // Illegal encodings recover through a fresh init count;
                    // ram_rdy is left as is since it only clears on reset.
                    state         <= S_INIT;
                    init_cnt      <= '0;
                    avl.avl_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avl_mem_responder.sv
// tb_avl_mem_responder: directed bench for avl_mem_responder covering init,
// read latency, aliasing, write/read collision, streaming and reset flush.
module tb_avl_mem_responder;

    localparam int DW  = 32;
    localparam int AW  = 29;
    localparam int LAT = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic ram_rdy;
    logic cmd_err;

    int   vectors    = 0;
    int   miscompares = 0;
    bit   exp_rdy;
    int   acc;
    int   stl;
    int   got;
    int   idx;
    int   guard;

    always #5 clk = ~clk;

    avl_mem_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) avl ();

    avl_mem_responder #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .MEM_ADDR_BITS(10),
        .RD_LATENCY   (LAT),
        .INIT_CYCLES  (16),
        .BUSY_PERIOD  (8),
        .STALL_CYCLES (2)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .avl    (avl.slave),
        .ram_rdy(ram_rdy),
        .cmd_err(cmd_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        avl.avl_write_req = 1'b0;
        avl.avl_read_req  = 1'b0;
        avl.avl_addr      = '0;
        avl.avl_wdata     = '0;
    endtask

    task automatic wait_rdy(input string tag);
        for (int i = 0; i < 300 && !avl.avl_ready; i++) tick();
        chk(tag, 32'(avl.avl_ready), 32'd1);
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        wait_rdy("wr_wait");
        avl.avl_write_req = 1'b1;
        avl.avl_addr      = AW'(a);
        avl.avl_wdata     = d;
        tick();
        avl.avl_write_req = 1'b0;
    endtask

    task automatic rd(input int a);
        wait_rdy("rd_wait");
        avl.avl_read_req = 1'b1;
        avl.avl_addr     = AW'(a);
        tick();
        avl.avl_read_req = 1'b0;
    endtask

    // Called right after the acceptance edge of a single read.
    task automatic check_read(input string tag, input logic [31:0] exp);
        for (int i = 1; i < LAT; i++) begin
            tick();
            chk({tag, "_early"}, 32'(avl.avl_rdata_valid), 32'd0);
        end
        tick();
        chk({tag, "_vld"}, 32'(avl.avl_rdata_valid), 32'd1);
        chk({tag, "_data"}, avl.avl_rdata, exp);
        tick();
        chk({tag, "_one"}, 32'(avl.avl_rdata_valid), 32'd0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ready"}, 32'(avl.avl_ready), 32'd0);
        chk({tag, "_ramrdy"}, 32'(ram_rdy), 32'd0);
        chk({tag, "_vld"}, 32'(avl.avl_rdata_valid), 32'd0);
        chk({tag, "_rdata"}, avl.avl_rdata, 32'd0);
        chk({tag, "_err"}, 32'(cmd_err), 32'd0);
    endtask

    // Expected avl_ready after one edge of the streaming phase.
    task automatic model_step(input bit accepted);
`ifdef AVL_RESP_STALL_EN
        if (accepted) begin
            if (acc % 8 == 0) begin
                exp_rdy = 1'b0;
                stl     = 2;
            end
        end else begin
            stl--;
            if (stl == 0) exp_rdy = 1'b1;
        end
`else
        if (!accepted) exp_rdy = 1'b1;
`endif
    endtask

    initial begin
        idle_bus();
        reset = 1'b0;
        tick();
        tick();
        check_reset("rst");

        // Release; reads held during init must be ignored.
        reset            = 1'b1;
        avl.avl_read_req = 1'b1;
        avl.avl_addr     = AW'(7);
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("init_rdy", {30'd0, avl.avl_ready, ram_rdy}, 32'd0);
            chk("init_vld", 32'(avl.avl_rdata_valid), 32'd0);
        end
        idle_bus();
        tick();
        chk("init_done", {30'd0, avl.avl_ready, ram_rdy}, 32'd3);

        // Read-after-write on consecutive cycles.
        wr(5, 32'hDEADBEEF);
        rd(5);
        check_read("raw", 32'hDEADBEEF);

        // 0x400 aliases onto 0x000.
        wr(32'h400, 32'h000000A5);
        rd(0);
        check_read("alias", 32'h000000A5);

        // Write and read together: write wins, read dropped, error sticks.
        wait_rdy("err_wait");
        avl.avl_write_req = 1'b1;
        avl.avl_read_req  = 1'b1;
        avl.avl_addr      = AW'(3);
        avl.avl_wdata     = 32'h1234;
        tick();
        idle_bus();
        chk("err_set", 32'(cmd_err), 32'd1);
        for (int i = 0; i < LAT + 2; i++) begin
            tick();
            chk("err_novld", 32'(avl.avl_rdata_valid), 32'd0);
        end
        rd(3);
        check_read("err_rd", 32'h1234);
        chk("err_sticky", 32'(cmd_err), 32'd1);

        // Streaming phase from a clean reset.
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        chk("rst2_err", 32'(cmd_err), 32'd0);
        wait_rdy("rst2_wait");
        exp_rdy = 1'b1;
        acc     = 0;
        stl     = 0;

        idx   = 0;
        guard = 0;
        while (idx < 20 && guard < 200) begin
            guard++;
            avl.avl_write_req = 1'b1;
            // While stalled, aim a bogus write at an already written word.
            avl.avl_addr  = AW'(exp_rdy ? idx : idx - 1);
            avl.avl_wdata = exp_rdy ? 32'(idx) : (32'hBAD00000 | 32'(idx));
            tick();
            if (exp_rdy) begin
                idx++;
                acc++;
                model_step(1'b1);
            end else begin
                model_step(1'b0);
            end
            chk("wr_rdy", 32'(avl.avl_ready), 32'(exp_rdy));
        end
        idle_bus();
        chk("wr_count", 32'(idx), 32'd20);

        idx   = 0;
        got   = 0;
        guard = 0;
        while ((idx < 20 || got < 20) && guard < 300) begin
            guard++;
            avl.avl_read_req = (idx < 20);
            avl.avl_addr     = AW'(idx < 20 ? idx : 0);
            tick();
            if (exp_rdy && idx < 20) begin
                idx++;
                acc++;
                model_step(1'b1);
            end else if (!exp_rdy) begin
                model_step(1'b0);
            end
            if (avl.avl_rdata_valid) begin
                chk("rd_seq", avl.avl_rdata, 32'(got));
                got++;
            end
            chk("rd_rdy", 32'(avl.avl_ready), 32'(exp_rdy));
        end
        idle_bus();
        chk("rd_count", 32'(got), 32'd20);
        for (int i = 0; i < LAT; i++) begin
            tick();
            chk("rd_extra", 32'(avl.avl_rdata_valid), 32'd0);
        end

        // Reset with reads in flight: nothing may come back.
        rd(1);
        rd(2);
        rd(4);
        tick();
        chk("flush_pre", 32'(avl.avl_rdata_valid), 32'd0);
        reset = 1'b0;
        tick();
        check_reset("flush_rst");
        tick();
        reset             = 1'b1;
        avl.avl_write_req = 1'b1;
        avl.avl_addr      = AW'(10);
        avl.avl_wdata     = 32'h0BAD0BAD;
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("flush_vld", 32'(avl.avl_rdata_valid), 32'd0);
            chk("flush_rdy", 32'(avl.avl_ready), 32'd0);
        end
        idle_bus();
        wait_rdy("flush_wait");
        rd(10);
        check_read("retain", 32'd10);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/avl_mem_responder.md
# avl_mem_responder

Avalon-MM slave responder for the Cyclone V memory-interface port, the target end of the frame buffer's write/read request stream. It accepts single-word write and read commands, stores data in an internal RAM, returns read data after a fixed pipeline latency, and models controller init and back-pressure through `ram_rdy` and `avl_ready`. It is used as the memory model in frame-buffer benches and as an on-chip stand-in for DDR in bring-up builds.

## Interface
- `DATA_WIDTH`, 32, word width.
- `ADDR_WIDTH`, 29, Avalon word-address width.
- `MEM_ADDR_BITS`, 10, internal storage depth of 2^MEM_ADDR_BITS words; `avl_addr[MEM_ADDR_BITS-1:0]` indexes it and upper bits alias.
- `RD_LATENCY`, 4, cycles from read acceptance to `avl_rdata_valid`; legal range 1..15.
- `INIT_CYCLES`, 16, cycles after reset release before `ram_rdy` rises; legal range 1..255.
- `BUSY_PERIOD`, 8, accepted commands between stalls; only used with stall enabled.
- `STALL_CYCLES`, 2, cycles `avl_ready` is held low per stall; legal range ≥1.
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-low.
- `avl_write_req` in 1: write command.
- `avl_read_req` in 1: read command.
- `avl_addr` in ADDR_WIDTH: command word address.
- `avl_wdata` in DATA_WIDTH: write data, sampled with the write command.
- `avl_ready` out 1: registered; a command is accepted only in a cycle where req and `avl_ready` are both high.
- `avl_rdata` out DATA_WIDTH: read data, valid only while `avl_rdata_valid` is high.
- `avl_rdata_valid` out 1: one-cycle pulse per accepted read.
- `ram_rdy` out 1: init complete.
- `cmd_err` out 1: sticky error flag.

## Operation
- Reset (`reset` low at an edge): next-cycle values are `avl_ready`=0, `ram_rdy`=0, `avl_rdata`=0, `avl_rdata_valid`=0, `cmd_err`=0. State goes to INIT and the read pipeline is flushed. RAM contents are not cleared.
- State machine, 2-bit, safe-encoded:
  - INIT: an 8-bit counter counts to INIT_CYCLES-1, then the block enters READY and `ram_rdy` and `avl_ready` go to 1 on the same edge.
  - READY: accepts commands.
  - STALL: `avl_ready`=0 for STALL_CYCLES, then returns to READY.
  - Unreachable encodings go to INIT.
- Accepted write: `mem[avl_addr[MEM_ADDR_BITS-1:0]] <= avl_wdata`.
- Accepted read: RAM is read at acceptance, and the data and valid bit travel through a RD_LATENCY-deep shift pipeline. Reads return in order, with exactly one valid pulse per accepted read and no reordering.
- Write and read both asserted while `avl_ready`=1: the write is performed, the read is dropped, and `cmd_err` is set.
- Req while `avl_ready`=0, or while `ram_rdy`=0: the command is ignored and produces no side effect.
- Read-after-write to the same address in consecutive accepted cycles returns the new data. Same-cycle read/write is the error case above.
- `ram_rdy` stays 1 until the next reset.

## Timing
- Write accepted at edge N: RAM updated at edge N. A read accepted at N+1 observes the update.
- Read accepted at edge N: `avl_rdata_valid`=1 and `avl_rdata` valid during the cycle following edge N+RD_LATENCY, for one cycle.
- Back-to-back reads on consecutive cycles produce back-to-back valid pulses.
- `avl_ready` falls at the edge on which the BUSY_PERIOD-th command is accepted, so the next cycle is not ready.
- Reset mid-read: in-flight reads are discarded and no valid pulse appears after reset.
- Throughput: one command per cycle while ready.

## Configuration
- `AVL_RESP_STALL_EN` defined:
  - A 16-bit accepted-command counter increments on each accepted command.
  - When it reaches BUSY_PERIOD, the block enters STALL and the counter clears.
  - Reset clears the counter.
- Not defined: STALL is never entered, `avl_ready`=`ram_rdy` after INIT, and no stall counter is synthesized.

## Test plan
- Reset release with INIT_CYCLES=16 -> `ram_rdy` and `avl_ready` stay 0 for 16 cycles, then both go to 1; all outputs are 0 during INIT.
- Write 0xDEADBEEF to addr 5, then read addr 5 on the next cycle (RD_LATENCY=4) -> `avl_rdata_valid` pulses once, 4 cycles after acceptance, with `avl_rdata`=0xDEADBEEF.
- 20 back-to-back writes with data=addr, then 20 back-to-back reads (stall enabled, BUSY_PERIOD=8, STALL_CYCLES=2) -> `avl_ready` drops for 2 cycles after every 8th acceptance; ignored cycles leave RAM unchanged; reads return data 0..19 in order.
- Assert write and read together at addr 3 with wdata 0x1234 -> `cmd_err`=1 and stays 1; a later read of addr 3 returns 0x1234; no valid pulse for the dropped read.
- Issue 3 reads, then assert reset 2 cycles later -> no `avl_rdata_valid` after reset; after re-init, a read of a previously written address returns the retained data.
- Address aliasing with MEM_ADDR_BITS=10: write 0xA5 to addr 0x400, then read addr 0x000 -> returns 0xA5.
